bitrev_reorder: RTL and testbench

BITREV_REORDER -- requirements
Module: bitrev_reorder

---
 rtl/bitrev_pkg.sv | 22 ++
 rtl/bitrev_addr_gen.sv | 50 +++++
 rtl/d1spram.sv | 36 +++
 rtl/bitrev_reorder.sv | 157 +++++++++++++++
 tb/tb_bitrev_reorder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reverse reorder buffer: mode encoding, bank and
// skid-buffer sizing, and the frame-length clamp.
package bitrev_pkg;

    typedef enum logic [1:0] {
        MODE_BITREV  = 2'd0,
        MODE_NATURAL = 2'd1,
        MODE_DIGREV4 = 2'd2,
        MODE_RSVD    = 2'd3
    } bitrev_mode_t;

    localparam int         NUM_BANKS  = 2;
    localparam logic [1:0] SKID_DEPTH = 2'd2;

    // Frame length is only meaningful in 1..log_max; anything else is pulled into range.
    function automatic int clamp_point(input int p, input int log_max);
        if (p > log_max) return log_max;
        if (p < 1)       return 1;
        return p;
    endfunction

endpackage

// File: rtl/bitrev_addr_gen.sv
// Combinational write-address permutation: bit reversal over `point` bits, identity,
// or base-4 digit reversal (the latter only when BITREV_RADIX4_EN is defined).
module bitrev_addr_gen
    import bitrev_pkg::*;
#(
    parameter int LOG = 13,
    parameter int PW  = $clog2(LOG) + 1
) (
    input  logic [LOG-1:0] i_k,
    input  logic [PW-1:0]  i_point,
    input  bitrev_mode_t   i_mode,
    output logic [LOG-1:0] o_addr
);

    logic [LOG-1:0] w_bit_full;
    logic [LOG-1:0] w_bit_rev;

    // Reverse all LOG bits, then drop the zeros that came from above bit point-1.
    always_comb begin
        // NOTE: default assigned first so no path through the block can infer a latch.
        w_bit_full = '0;
        for (int i = 0; i < LOG; i++) w_bit_full[i] = i_k[LOG-1-i];
    end
    assign w_bit_rev = w_bit_full >> (LOG - int'(i_point));

`ifdef BITREV_RADIX4_EN
    localparam int DIG = LOG / 2;

    logic [LOG-1:0] w_dig_full;
    logic [LOG-1:0] w_dig_rev;

    always_comb begin
        w_dig_full = '0;
        for (int j = 0; j < DIG; j++) w_dig_full[2*j +: 2] = i_k[2*(DIG-1-j) +: 2];
    end
    assign w_dig_rev = w_dig_full >> (2*DIG - 2*(int'(i_point) / 2));

    // Odd point has no whole base-4 digit count, so it falls back to bit reversal.
    always_comb begin
        case (i_mode)
            MODE_NATURAL: o_addr = i_k;
            MODE_DIGREV4: o_addr = i_point[0] ? w_bit_rev : w_dig_rev;
            default:      o_addr = w_bit_rev;
        endcase
    end
`else
    assign o_addr = (i_mode == MODE_NATURAL) ? i_k : w_bit_rev;
`endif

endmodule

// File: rtl/d1spram.sv
// Single-port RAM with one-cycle read latency. SRAM != 0 models a macro that holds
// its read data between reads; SRAM == 0 models a flop array read on every enable.
module d1spram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8192,
    parameter int SRAM  = 0
) (
    input  logic                     clk,
    input  logic                     i_ce,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the storage array has no reset; a frame is always written in full before it is read.
    always_ff @(posedge clk) begin
        if (i_ce && i_we) r_mem[i_addr] <= i_wdata;
    end

    if (SRAM != 0) begin : g_macro
        always_ff @(posedge clk) begin
            if (i_ce && !i_we) r_rdata <= r_mem[i_addr];
        end
    end else begin : g_flop
        always_ff @(posedge clk) begin
            if (i_ce) r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bitrev_reorder.sv
// Ping-pong bank reorder buffer: frames are written permuted, read in natural order,
// and leave through a 2-entry skid buffer. BITREV_RADIX4_EN enables the base-4 mode.
`ifndef FFT_SRAM
`define FFT_SRAM 0
`endif

module bitrev_reorder
    import bitrev_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int MAX_POINT  = 8192,
    parameter  int SRAM       = `FFT_SRAM,
    localparam int LOG        = $clog2(MAX_POINT),
    localparam int PW         = $clog2(LOG) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PW-1:0]         point,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam logic [LOG-1:0] CNT_ONES = '1;

    logic [LOG-1:0]        r_wr_cnt, r_rd_cnt;
    logic                  r_wr_bank, r_rd_bank;
    logic [NUM_BANKS-1:0]  r_full;
    logic [PW-1:0]         r_bank_point [NUM_BANKS];
    bitrev_mode_t          r_bank_mode  [NUM_BANKS];
    logic                  r_rd_pend, r_pend_bank, r_pend_last;
    logic [DATA_WIDTH-1:0] r_sk_data [2];
    logic [1:0]            r_sk_last;
    logic [1:0]            r_sk_cnt;

    logic                  w_first, w_wr_fire, w_wr_last, w_rd_fire, w_rd_last, w_pop;
    logic [PW-1:0]         w_wr_point;
    bitrev_mode_t          w_wr_mode;
    logic [LOG-1:0]        w_wr_addr, w_wr_max, w_rd_max;
    logic [1:0]            w_sk_after_pop;
    logic [DATA_WIDTH-1:0] w_rdata [NUM_BANKS];

    // The first beat uses the live controls; later beats use what that beat stored.
    assign w_first    = (r_wr_cnt == '0);
    assign w_wr_point = w_first ? PW'(clamp_point(int'(point), LOG)) : r_bank_point[r_wr_bank];
    assign w_wr_mode  = w_first ? bitrev_mode_t'(mode) : r_bank_mode[r_wr_bank];
    assign w_wr_max   = CNT_ONES >> (LOG - int'(w_wr_point));
    assign w_rd_max   = CNT_ONES >> (LOG - int'(r_bank_point[r_rd_bank]));

    assign in_ready  = !rst && !r_full[r_wr_bank];
    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_last = w_wr_fire && (r_wr_cnt == w_wr_max);

    // Counting the slot freed by this cycle's pop lets a steady stream run without bubbles.
    assign w_pop          = out_valid && out_ready;
    assign w_sk_after_pop = r_sk_cnt - {1'b0, w_pop};
    assign w_rd_fire      = !rst && r_full[r_rd_bank] &&
                            ((w_sk_after_pop + {1'b0, r_rd_pend}) < SKID_DEPTH);
    assign w_rd_last      = w_rd_fire && (r_rd_cnt == w_rd_max);

    bitrev_addr_gen #(.LOG(LOG), .PW(PW)) u_addr_gen (
        .i_k     (r_wr_cnt),
        .i_point (w_wr_point),
        .i_mode  (w_wr_mode),
        .o_addr  (w_wr_addr)
    );

    // Writes only target a free bank and reads only a full one, so a bank never sees both.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_wr_sel, w_rd_sel;
        assign w_wr_sel = w_wr_fire && (r_wr_bank == 1'(b));
        assign w_rd_sel = w_rd_fire && (r_rd_bank == 1'(b));

        d1spram #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_POINT), .SRAM(SRAM)) u_ram (
            .clk     (clk),
            .i_ce    (w_wr_sel || w_rd_sel),
            .i_we    (w_wr_sel),
            .i_addr  (w_wr_sel ? w_wr_addr : r_rd_cnt),
            .i_wdata (in_data),
            .o_rdata (w_rdata[b])
        );
    end

    // NOTE: all state uses <= so every register samples pre-edge values, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_full          <= '0;
            r_bank_point[0] <= '0;
            r_bank_point[1] <= '0;
            r_bank_mode[0]  <= MODE_BITREV;
            r_bank_mode[1]  <= MODE_BITREV;
            r_rd_pend       <= 1'b0;
            r_pend_bank     <= 1'b0;
            r_pend_last     <= 1'b0;
            r_sk_data[0]    <= '0;
            r_sk_data[1]    <= '0;
            r_sk_last       <= '0;
            r_sk_cnt        <= '0;
        end else begin
            if (w_wr_fire) begin
                if (w_first) begin
                    r_bank_point[r_wr_bank] <= w_wr_point;
                    r_bank_mode[r_wr_bank]  <= w_wr_mode;
                end
                if (w_wr_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= !r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + LOG'(1);
                end
            end

            if (w_rd_fire) begin
                if (w_rd_last) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= !r_rd_bank;
                end else begin
                    r_rd_cnt <= r_rd_cnt + LOG'(1);
                end
            end

            if (w_wr_last) r_full[r_wr_bank] <= 1'b1;
            if (w_rd_last) r_full[r_rd_bank] <= 1'b0;

            r_rd_pend   <= w_rd_fire;
            r_pend_bank <= r_rd_bank;
            r_pend_last <= w_rd_last;

            // Head shifts on pop; returning read data lands in the first free slot.
            if (w_pop) begin
                r_sk_data[0] <= r_sk_data[1];
                r_sk_last[0] <= r_sk_last[1];
            end
            if (r_rd_pend) begin
                r_sk_data[w_sk_after_pop[0]] <= w_rdata[r_pend_bank];
                r_sk_last[w_sk_after_pop[0]] <= r_pend_last;
            end
            r_sk_cnt <= w_sk_after_pop + {1'b0, r_rd_pend};
        end
    end

    assign out_valid = !rst && (r_sk_cnt != 2'd0);
    assign out_last  = out_valid && r_sk_last[0];
    assign out_data  = rst ? '0 : r_sk_data[0];
    assign busy      = !rst && ((r_full != '0) || (r_wr_cnt != '0) || r_rd_pend || (r_sk_cnt != 2'd0));

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed-frame bench for bitrev_reorder: expected samples are queued when a frame is
// issued, and an independent output monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_bitrev_reorder;

    localparam int DW   = 16;
    localparam int MAXP = 16;
    localparam int PW   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] point = '0;
    logic [1:0]    mode = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last;
    logic          out_ready = 1'b1;
    logic          busy;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_stall = 0;
    int   t_hs = 0;
    bit   rand_ready = 1'b0;

    // Hand-computed read orders: entry i is the input index that appears as output i.
    int id2[16]   = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int rev4[16]  = '{0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int rev8[16]  = '{0, 4, 2, 6, 1, 5, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    int nat8[16]  = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    int rev16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int dig16[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    bitrev_reorder #(.DATA_WIDTH(DW), .MAX_POINT(MAXP)) dut (
        .clk       (clk),
        .rst       (rst),
        .point     (point),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic push_frame(input int base, input int ord[16], input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = DW'(base + ord[i]);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat is accepted.
    task automatic send_beat(input logic [DW-1:0] d);
        int waits = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            waits++;
            if (waits > 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL in_ready_timeout: in_ready=0 for %0d cycles, expected 1", waits);
                finish_run();
            end
            @(negedge clk);
        end
        n_stall += waits;
        @(posedge clk);
        #1;
        t_hs = cyc;
    endtask

    // Controls are scrambled after the first beat; the frame must keep its sampled values.
    task automatic send_frame(input int p, input int m, input int base, input int n);
        point = PW'(p);
        mode  = 2'(m);
        for (int k = 0; k < n; k++) begin
            send_beat(DW'(base + k));
            if (k == 0) begin
                point = PW'(1);
                mode  = 2'd1;
            end
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: stability while stalled, then scoreboard compare on each handshake.
    initial begin
        logic          hold_pending;
        logic [DW-1:0] hold_data;
        logic          hold_last;
        exp_t          e;
        hold_pending = 1'b0;
        hold_data    = '0;
        hold_last    = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_pending) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
                check("hold_last", 32'(out_last), 32'(hold_last));
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
            hold_last    = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        finish_run();
    end

    initial begin
        int t_last;
        int t_wait;
        int seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Bit reverse, point 3, with first-output latency
        push_frame(0, rev8, 8);
        send_frame(3, 0, 0, 8);
        in_valid = 1'b0;
        t_last   = t_hs;
        t_wait   = 0;
        @(negedge clk);
        while (!out_valid && t_wait < 20) begin
            @(negedge clk);
            t_wait++;
        end
        check("t1_first_out_latency", 32'(cyc - t_last), 32'd2);
        drain("t1");

        // Natural order
        push_frame(100, nat8, 8);
        send_frame(3, 1, 100, 8);
        in_valid = 1'b0;
        drain("t2");

        // Mode 2, point 4
`ifdef BITREV_RADIX4_EN
        push_frame(200, dig16, 16);
`else
        push_frame(200, rev16, 16);
`endif
        send_frame(4, 2, 200, 16);
        in_valid = 1'b0;
        drain("t3");

        // Back-to-back point-2 frames must never see in_ready low
        n_stall = 0;
        push_frame(300, rev4, 4);
        push_frame(304, rev4, 4);
        send_frame(2, 0, 300, 4);
        send_frame(2, 0, 304, 4);
        in_valid = 1'b0;
        check("t4_in_ready_stall_cycles", 32'(n_stall), 32'd0);
        drain("t4");

        // Random output backpressure across a point-3 then point-2 frame
        rand_ready = 1'b1;
        push_frame(400, rev8, 8);
        push_frame(408, rev4, 4);
        send_frame(3, 0, 400, 8);
        send_frame(2, 0, 408, 4);
        in_valid = 1'b0;
        drain("t5");
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;

        // Reset after 5 of 8 beats: the partial frame must vanish
        send_frame(3, 0, 500, 5);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_in_ready_after_rst", 32'(in_ready), 32'd1);
        check("t6_busy_after_rst", 32'(busy), 32'd0);
        check("t6_out_valid_after_rst", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("t6_no_stale_output", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        push_frame(600, rev8, 8);
        send_frame(3, 0, 600, 8);
        in_valid = 1'b0;
        drain("t6");

        // point 0 clamps to 1, point 7 clamps to LOG = 4
        push_frame(700, id2, 2);
        send_frame(0, 0, 700, 2);
        push_frame(800, rev16, 16);
        send_frame(7, 0, 800, 16);
        in_valid = 1'b0;
        drain("t7");

        @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);
        finish_run();
    end

endmodule
